aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 81 ++++++++
 rtl/aes_inv_sbox.sv | 33 +++
 rtl/aes_inv_cipher_iter.sv | 149 ++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the iterative AES-128
// inverse cipher.
//
// Contents:
//   NR, AES_BLK_W, RK_AW  - round count, block width, round-key address width
//   aes_inv_st_e          - inverse-cipher FSM states
//   xtime, gf_mul_09/0b/0d/0e, inv_shift_rows, inv_mix_column
package aes_pkg;

   localparam int unsigned NR        = 10;
   localparam int unsigned AES_BLK_W = 128;
   localparam int unsigned RK_AW     = 4;

   typedef enum logic [2:0] {
      StIdle,
      StKeyw,
      StRound,
      StFinal,
      StDone
   } aes_inv_st_e;

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul_09(input logic [7:0] b);
      logic [7:0] x8;
      x8 = xtime(xtime(xtime(b)));
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul_0b(input logic [7:0] b);
      logic [7:0] x2, x8;
      x2 = xtime(b);
      x8 = xtime(xtime(x2));
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul_0d(input logic [7:0] b);
      logic [7:0] x4, x8;
      x4 = xtime(xtime(b));
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul_0e(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Byte k sits at [127-8k -: 8]; row = k % 4, column = k / 4.
   // Row r is rotated right by r byte positions.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c - row + 4) % 4) + row) -: 8];
         end
      end
      return r;
   endfunction

   // One column, row 0 in [31:24].
   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mul_0e(a0) ^ gf_mul_0b(a1) ^ gf_mul_0d(a2) ^ gf_mul_09(a3),
              gf_mul_09(a0) ^ gf_mul_0e(a1) ^ gf_mul_0b(a2) ^ gf_mul_0d(a3),
              gf_mul_0d(a0) ^ gf_mul_09(a1) ^ gf_mul_0e(a2) ^ gf_mul_0b(a3),
              gf_mul_0b(a0) ^ gf_mul_0d(a1) ^ gf_mul_09(a2) ^ gf_mul_0e(a3)};
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
//
// Ports:
//   data_i  8-bit input byte
//   data_o  8-bit InvSubBytes result
module aes_inv_sbox (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   // Element 0 is the leftmost byte of the concatenation.
   localparam logic [0:255][7:0] InvSboxLut = {
      128'h52096ad53036a538_bf40a39e81f3d7fb,
      128'h7ce339829b2fff87_348e4344c4dee9cb,
      128'h547b9432a6c2233d_ee4c950b42fac34e,
      128'h082ea16628d924b2_765ba2496d8bd125,
      128'h72f8f66486689816_d4a45ccc5d65b692,
      128'h6c704850fdedb9da_5e154657a78d9d84,
      128'h90d8ab008cbcd30a_f7e45805b8b34506,
      128'hd02c1e8fca3f0f02_c1afbd0301138a6b,
      128'h3a9111414f67dcea_97f2cfcef0b4e673,
      128'h96ac7422e7ad3585_e2f937e81c75df6e,
      128'h47f11a711d29c589_6fb7620eaa18be1b,
      128'hfc563e4bc6d27920_9adbc0fe78cd5af4,
      128'h1fdda8338807c731_b11210592780ec5f,
      128'h60517fa919b54a0d_2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0_c8ebbb3c83539961,
      128'h172b047eba77d626_e169146355210c7d
   };

   assign data_o = InvSboxLut[data_i];

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, 12-cycle latency
// from input handshake to out_valid. Round keys come from an external expanded-key
// store with a 1-cycle synchronous read.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     ciphertext handshake, in_data 128-bit (FIPS-197 byte order)
//   rk_addr               registered round-key index (10 down to 0)
//   rk_data               key[rk_addr] from the previous cycle
//   out_valid/out_ready   plaintext handshake, out_data 128-bit
//
// Build option: AES_INV_ZEROIZE_EN clears state and latched ciphertext on the output
// handshake and forces out_data to 0 while out_valid is low.
module aes_inv_cipher_iter #(
   parameter int unsigned NR    = 10,
   parameter int unsigned RK_AW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   output logic [RK_AW-1:0] rk_addr,
   input  logic [127:0]     rk_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data
);

   import aes_pkg::*;

   aes_inv_st_e            st_q, st_d;
   logic [AES_BLK_W-1:0]   ct_q, ct_d;
   logic [AES_BLK_W-1:0]   state_q, state_d;
   logic [RK_AW-1:0]       cnt_q, cnt_d;
   logic [RK_AW-1:0]       rk_addr_q, rk_addr_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;

   logic [AES_BLK_W-1:0]   isr, isb, ark, imc;

   // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
   assign isr = inv_shift_rows(state_q);

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_inv_sbox u_sbox (
         .data_i(isr[127 - 8 * i -: 8]),
         .data_o(isb[127 - 8 * i -: 8])
      );
   end

   assign ark = isb ^ rk_data;

   always_comb begin
      imc = '0;
      for (int c = 0; c < 4; c++) begin
         imc[127 - 32 * c -: 32] = inv_mix_column(ark[127 - 32 * c -: 32]);
      end
   end

   // rk_addr always holds the index needed one cycle later, so rk_data lines up with
   // the round being computed.
   always_comb begin
      st_d        = st_q;
      ct_d        = ct_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      rk_addr_d   = rk_addr_q;
      out_valid_d = out_valid_q;

      unique case (st_q)
         StIdle: begin
            if (in_valid && in_ready_q) begin
               ct_d      = in_data;
               rk_addr_d = RK_AW'(NR - 1);
               st_d      = StKeyw;
            end
         end
         StKeyw: begin
            state_d   = ct_q ^ rk_data;
            cnt_d     = RK_AW'(NR - 1);
            rk_addr_d = rk_addr_q - RK_AW'(1);
            st_d      = StRound;
         end
         StRound: begin
            state_d = imc;
            cnt_d   = cnt_q - RK_AW'(1);
            if (rk_addr_q != '0) begin
               rk_addr_d = rk_addr_q - RK_AW'(1);
            end
            if (cnt_q == RK_AW'(1)) begin
               st_d = StFinal;
            end
         end
         StFinal: begin
            state_d     = ark;
            out_valid_d = 1'b1;
            st_d        = StDone;
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               rk_addr_d   = RK_AW'(NR);
               st_d        = StIdle;
`ifdef AES_INV_ZEROIZE_EN
               state_d     = '0;
               ct_d        = '0;
`endif
            end
         end
         default: begin
            st_d = StIdle;
         end
      endcase

      in_ready_d = (st_d == StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q        <= StIdle;
         ct_q        <= '0;
         state_q     <= '0;
         cnt_q       <= '0;
         rk_addr_q   <= RK_AW'(NR);
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         ct_q        <= ct_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rk_addr_q   <= rk_addr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign rk_addr   = rk_addr_q;
   assign out_valid = out_valid_q;

`ifdef AES_INV_ZEROIZE_EN
   assign out_data = out_valid_q ? state_q : '0;
`else
   assign out_data = state_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: a key-store model expands the key and
// serves round keys with 1-cycle latency; expected plaintexts are FIPS-197 vectors.
module tb_aes_inv_cipher_iter;

   localparam int unsigned NR    = 10;
   localparam int unsigned RK_AW = 4;

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [127:0]     in_data = '0;
   logic [RK_AW-1:0] rk_addr;
   logic [127:0]     rk_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [127:0]     out_data;

   logic [127:0]     rk_mem [0:10];

   typedef struct {
      logic [127:0] pt;
      int           t0;
   } exp_t;

   exp_t         sb_q[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   bit           seen = 1'b0;
   bit           post_pend = 1'b0;
   logic [127:0] held = '0;
   logic [127:0] last_pt = '0;

   aes_inv_cipher_iter #(
      .NR(NR),
      .RK_AW(RK_AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .rk_addr(rk_addr),
      .rk_data(rk_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Expanded-key store: synchronous read, one cycle of latency.
   always @(posedge clk) rk_data <= (rk_addr <= 4'(NR)) ? rk_mem[rk_addr] : '0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box from first principles: inverse as b^254, then the affine map.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t = {sbox_fwd(t[23:16]), sbox_fwd(t[15:8]), sbox_fwd(t[7:0]), sbox_fwd(t[31:24])}
                ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i - 4] ^ t;
      end
      for (int k = 0; k <= 10; k++) rk_mem[k] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit keep_valid);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ct;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         timeout("accept");
         in_valid = 1'b0;
         return;
      end
      sb_q.push_back('{pt: pt, t0: cyc});
      @(negedge clk);
      if (keep_valid) in_data = ~ct;
      else in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || post_pend) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0 || post_pend) timeout("wait_idle");
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) timeout("wait_valid");
   endtask

   // Output monitor: latency, stability under back-pressure, data, post-handshake view.
   initial begin
      exp_t         it;
      logic [127:0] post_exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            seen      = 1'b0;
            post_pend = 1'b0;
            continue;
         end
         if (post_pend) begin
            post_pend = 1'b0;
`ifdef AES_INV_ZEROIZE_EN
            post_exp = '0;
`else
            post_exp = last_pt;
`endif
            check("post_hs_valid", 128'(out_valid), 128'd0);
            check("post_hs_data", out_data, post_exp);
         end
         if (out_valid) begin
            check("busy_in_ready", 128'(in_ready), 128'd0);
            if (sb_q.size() == 0) begin
               timeout("unexpected_out_valid");
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  held = out_data;
                  check("latency", 128'(cyc - sb_q[0].t0), 128'd12);
               end else begin
                  check("hold_stable", out_data, held);
               end
               if (out_ready) begin
                  it = sb_q.pop_front();
                  check("plaintext", out_data, it.pt);
                  last_pt   = it.pt;
                  seen      = 1'b0;
                  post_pend = 1'b1;
               end
            end
         end
      end
   end

   // Round-key address trace: 10 in the accept cycle, then 9..0 on following cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && in_valid && in_ready) begin
            for (int k = 10; k >= 0; k--) begin
               if (rst) break;
               check("rk_addr_trace", 128'(rk_addr), 128'(k));
               if (k > 0) @(negedge clk);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      load_key(KEY_C1);
      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'd0);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_rk_addr", 128'(rk_addr), 128'(NR));
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_rst", 128'(in_ready), 128'd1);

      // FIPS-197 C.1
      send(CT_C1, PT_C1, 1'b0);
      wait_idle();

      // FIPS-197 Appendix B
      load_key(KEY_B);
      send(CT_B, PT_B, 1'b0);
      wait_idle();

      // Back-pressure: hold 5 cycles in DONE, then release
      out_ready = 1'b0;
      send(CT_B, PT_B, 1'b0);
      wait_valid();
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_hs", 128'(in_ready), 128'd1);
      load_key(KEY_C1);
      send(CT_C1, PT_C1, 1'b0);
      wait_idle();

      // in_valid held high with changing data while busy
      send(CT_C1, PT_C1, 1'b1);
      n = 0;
      while (!out_valid && n < 30) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      if (!out_valid) timeout("busy_wait_valid");
      wait_idle();

      // Reset pulse in the middle of a block
      send(CT_C1, PT_C1, 1'b0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("abort_out_valid", 128'(out_valid), 128'd0);
      check("abort_in_ready", 128'(in_ready), 128'd0);
      check("abort_rk_addr", 128'(rk_addr), 128'(NR));
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_after_abort", 128'(in_ready), 128'd1);
      repeat (14) @(negedge clk);
      check("no_valid_after_abort", 128'(out_valid), 128'd0);
      send(CT_C1, PT_C1, 1'b0);
      wait_idle();

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
